siso_shift_ctrl: RTL and testbench

Sequencing controller for the serial-in/serial-out shift register datapath. It accepts a parallel word on a start request and drives the shift register's serial input one bit per clock, MSB first. It then flushes the register's pipeline so the last data bit reaches the register output, and reports completion with a one-cycle `done` pulse. It sits between a parallel producer and a `DEPTH`-stage shift register instance.

---
 rtl/siso_shift_ctrl.sv | 118 +++++++++++
 tb/tb_siso_shift_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/siso_shift_ctrl.sv
// Serial-in/serial-out shift register sequencer: loads a parallel word, streams it MSB first,
// then flushes the downstream register. Optional even-parity bit controlled by SISO_CTRL_PARITY_EN.
module siso_shift_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ser_d,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

`ifdef SISO_CTRL_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + DEPTH + 2);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
`ifdef SISO_CTRL_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
`ifdef SISO_CTRL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
`ifdef SISO_CTRL_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
`ifdef SISO_CTRL_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = din;
          cnt_d   = '0;
`ifdef SISO_CTRL_PARITY_EN
          par_d   = ^din;
`endif
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so start/din never reach them combinationally.
  always_comb begin
    ser_d  = 1'b0;
    ser_en = (state_q == S_SHIFT) || (state_q == S_FLUSH);
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    if (state_q == S_SHIFT) begin
`ifdef SISO_CTRL_PARITY_EN
      ser_d = (cnt_q == CW'(WIDTH)) ? par_q : shreg_q[WIDTH-1];
`else
      ser_d = shreg_q[WIDTH-1];
`endif
    end
  end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Directed + randomized bench for siso_shift_ctrl; expected output stream derived from the
// transfer timeline (phase number within a transfer) rather than from the controller's state.
module tb_siso_shift_ctrl;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
`ifdef SISO_CTRL_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned SPAN = NBITS + DEPTH + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] din;
  logic             ser_d, ser_en, busy, done;

  int unsigned ntests = 0;
  int unsigned nfail  = 0;

  siso_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .ser_d (ser_d),
    .ser_en(ser_en),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // {ser_d, ser_en, busy, done} expected in cycle 'phase' after the accepting edge (0 = idle)
  function automatic logic [3:0] expect_at(int unsigned phase, logic [WIDTH-1:0] w);
    if (phase >= 1 && phase <= WIDTH)       return {w[WIDTH-phase], 3'b110};
    if (phase >= 1 && phase <= NBITS)       return {^w, 3'b110};
    if (phase >= 1 && phase <= NBITS+DEPTH) return 4'b0110;
    if (phase == NBITS + DEPTH + 1)         return 4'b0011;
    return 4'b0000;
  endfunction

  task automatic check(input string tag, input int unsigned cyc, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {ser_d, ser_en, busy, done};
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cycle %0d: observed {d,en,busy,done}=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Start one transfer on the next rising edge, check every cycle through the following idle
  // cycle, and optionally pulse start (with a different din) in cycles poke_a / poke_b.
  task automatic transfer(input string tag, input logic [WIDTH-1:0] w,
                          input int unsigned poke_a, input int unsigned poke_b);
    int unsigned ndone;
    ndone = 0;
    din   = w;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    din   = WIDTH'($urandom);
    for (int unsigned k = 1; k <= SPAN; k++) begin
      @(negedge clk);
      check(tag, k, expect_at(k, w));
      if (done) ndone++;
      start = (k == poke_a) || (k == poke_b);
      din   = ~w;
    end
    start = 1'b0;
    ntests++;
    assert (ndone == 1) else begin
      nfail++;
      $error("FAIL %s done_count: observed=%0d expected=1", tag, ndone);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] w;

    // Reset held with start asserted: everything stays low
    rst_n = 1'b0;
    start = 1'b1;
    din   = 8'hA5;
    #2;
    check("reset_async", 0, 4'b0000);
    for (int unsigned i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("reset_held", i, 4'b0000);
    end
    rst_n = 1'b1;
    transfer("post_reset_A5", 8'hA5, 0, 0);

    // Directed words, including parity-distinguishing ones
    transfer("word_07", 8'h07, 0, 0);
    transfer("word_A5", 8'hA5, 0, 0);
    transfer("word_00", 8'h00, 0, 0);
    transfer("word_FF", 8'hFF, 0, 0);

    // start ignored in SHIFT cycle 3 and in the DONE cycle
    transfer("ignore_start", 8'hA5, 3, NBITS + DEPTH + 1);

    // start held high for 40 edges: accepted every SPAN cycles
    din   = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    for (int unsigned c = 1; c <= 42; c++) begin
      @(negedge clk);
      check("held_start", c, expect_at(c % SPAN, 8'hFF));
      if (c == 40) start = 1'b0;
    end

    // Asynchronous reset in the middle of SHIFT cycle 5
    w     = 8'h96;
    din   = w;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int unsigned k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("pre_abort", k, expect_at(k, w));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async", 5, 4'b0000);
    for (int unsigned i = 6; i <= 8; i++) begin
      @(negedge clk);
      check("abort_held", i, 4'b0000);
    end
    rst_n = 1'b1;
    transfer("after_abort_3C", 8'h3C, 0, 0);

    // Randomized words with random ignored start pulses while busy
    for (int unsigned n = 0; n < 8; n++) begin
      transfer("random", WIDTH'($urandom),
               $urandom_range(NBITS + DEPTH + 1, 1),
               ($urandom_range(1, 0) == 1) ? NBITS + DEPTH + 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
